// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier with a start/busy/done handshake.
// Retires two multiplier bits per clock; handles signed and unsigned operands.
module booth_radix4_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Q,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned EXT  = WIDTH + 2;
    localparam int unsigned AW   = EXT + 2;
    localparam int unsigned ITER = EXT / 2;
    localparam int unsigned CW   = $clog2(ITER + 1);

    // Reject widths that cannot be recoded in whole radix-4 digits
    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("booth_radix4_multiplier: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   a;
    logic [EXT-1:0]  qr;
    logic            q_m1;
    logic [EXT-1:0]  mx;
    logic [CW-1:0]   cnt;

    logic [AW-1:0]   mx_w;
    logic [AW-1:0]   mx2_w;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   a_sum;
    logic [AW-1:0]   a_next;
    logic [EXT-1:0]  qr_next;
    logic [2:0]      digit;
    logic            m_sx;
    logic            q_sx;

    // Booth digit selection, partial-product add and the 2-bit arithmetic shift
    always_comb begin
        mx_w    = {{2{mx[EXT-1]}}, mx};
        mx2_w   = {mx_w[AW-2:0], 1'b0};
        digit   = {qr[1:0], q_m1};
        addend  = '0;
        case (digit)
            3'b001, 3'b010: addend = mx_w;
            3'b011:         addend = mx2_w;
            3'b100:         addend = -mx2_w;
            3'b101, 3'b110: addend = -mx_w;
            default:        addend = '0;
        endcase
        a_sum   = a + addend;
        a_next  = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
        qr_next = {a_sum[1:0], qr[EXT-1:2]};
        m_sx    = signed_mode & M[WIDTH-1];
        q_sx    = signed_mode & Q[WIDTH-1];
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            a     <= '0;
            qr    <= '0;
            q_m1  <= 1'b0;
            mx    <= '0;
            cnt   <= '0;
            P     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mx    <= {{2{m_sx}}, M};
                        qr    <= {{2{q_sx}}, Q};
                        a     <= '0;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    a    <= a_next;
                    qr   <= qr_next;
                    q_m1 <= qr[1];
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) begin
                        P     <= {a_next[WIDTH-3:0], qr_next};
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench: WIDTH=8 and WIDTH=16 instances checked every cycle
// against an arithmetic model of product, latency and handshake timing.
module tb_booth_radix4_multiplier;

    localparam int unsigned IT8  = 5;
    localparam int unsigned IT16 = 9;

    logic        clk;
    logic        reset_n;
    logic        start8, sm8, start16, sm16;
    logic [7:0]  m8, q8;
    logic [15:0] m16, q16;
    logic [15:0] p8;
    logic [31:0] p16;
    logic        busy8, done8, busy16, done16;

    int     vec;
    int     errs;
    int     cyc;
    int     rem8, rem16;
    longint pend8, pend16, ep8, ep16;

    booth_radix4_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .signed_mode(sm8),
        .M(m8), .Q(q8), .P(p8), .busy(busy8), .done(done8)
    );

    booth_radix4_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .signed_mode(sm16),
        .M(m16), .Q(q16), .P(p16), .busy(busy16), .done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact product of two w-bit operands, truncated to 2w bits
    function automatic longint prod(input int w, input bit sm, input longint m, input longint q);
        longint x;
        longint y;
        x = m;
        y = q;
        if (sm) begin
            if (x[w-1]) x = x - (longint'(1) << w);
            if (y[w-1]) y = y - (longint'(1) << w);
        end
        return (x * y) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Timing model: rem counts cycles left until idle; done when rem==1
    task automatic mdl(input bit st, input bit sm, input longint m, input longint q,
                       input int w, input int it,
                       inout int rem, inout longint pend, inout longint ep);
        if (!reset_n) begin
            rem = 0;
            ep  = 0;
        end else if (rem == 0) begin
            if (st) begin
                rem  = it + 1;
                pend = prod(w, sm, m, q);
            end
        end else begin
            rem = rem - 1;
            if (rem == 1) ep = pend;
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        vec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Advance one clock; update the model for the edge just taken and compare
    task automatic step();
        @(negedge clk);
        cyc++;
        mdl(start8,  sm8,  longint'(m8),  longint'(q8),  8,  IT8,  rem8,  pend8,  ep8);
        mdl(start16, sm16, longint'(m16), longint'(q16), 16, IT16, rem16, pend16, ep16);
        chk("p8",     longint'(p8),     ep8);
        chk("busy8",  longint'(busy8),  longint'(rem8 > 0));
        chk("done8",  longint'(done8),  longint'(rem8 == 1));
        chk("p16",    longint'(p16),    ep16);
        chk("busy16", longint'(busy16), longint'(rem16 > 0));
        chk("done16", longint'(done16), longint'(rem16 == 1));
    endtask

    // One full operation on the selected instance, pinned to a literal result
    task automatic run_op(input int sel, input bit sm, input logic [15:0] m, input logic [15:0] q,
                          input longint lit, input string nm);
        int n;
        if (sel == 0) begin
            sm8 = sm; m8 = m[7:0]; q8 = q[7:0]; start8 = 1'b1;
        end else begin
            sm16 = sm; m16 = m; q16 = q; start16 = 1'b1;
        end
        step();
        start8 = 1'b0; start16 = 1'b0;
        m8 = 8'($urandom); q8 = 8'($urandom); sm8 = ~sm8;
        m16 = 16'($urandom); q16 = 16'($urandom); sm16 = ~sm16;
        n = 0;
        while (((sel == 0) ? done8 : done16) == 1'b0 && n < 30) begin
            step();
            n++;
        end
        chk({nm, "_latency"}, longint'(n), longint'((sel == 0) ? IT8 : IT16));
        chk({nm, "_p"}, (sel == 0) ? longint'(p8) : longint'(p16), lit);
        step();
    endtask

    function automatic logic [15:0] pick(input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        case ($urandom_range(0, 7))
            0:       return 16'd0;
            1:       return 16'(mask);
            2:       return 16'(32'd1 << (w - 1));
            3:       return 16'((32'd1 << (w - 1)) - 32'd1);
            default: return 16'($urandom & mask);
        endcase
    endfunction

    initial begin
        int n;
        vec = 0; errs = 0; cyc = 0;
        rem8 = 0; rem16 = 0; pend8 = 0; pend16 = 0; ep8 = 0; ep16 = 0;
        reset_n = 1'b0;
        start8 = 1'b0; sm8 = 1'b0; m8 = '0; q8 = '0;
        start16 = 1'b0; sm16 = 1'b0; m16 = '0; q16 = '0;
        step();
        step();
        chk("reset_p8", longint'(p8), 0);
        chk("reset_busy8", longint'(busy8), 0);
        reset_n = 1'b1;
        step();

        // Directed corner cases, literal results
        run_op(0, 1'b1, 16'h0080, 16'h0080, 64'h4000, "t1_minmin");
        run_op(0, 1'b0, 16'h00FF, 16'h00FF, 64'hFE01, "t2_umax");
        run_op(0, 1'b1, 16'h00FF, 16'h00FF, 64'h0001, "t2_sneg1");
        run_op(0, 1'b1, 16'h0007, 16'h00FD, 64'hFFEB, "t3_7xm3");
        run_op(0, 1'b1, 16'h0000, 16'h00FF, 64'h0000, "t3_zero");
        run_op(1, 1'b1, 16'h8000, 16'h8000, 64'h4000_0000, "w16_minmin");
        run_op(1, 1'b0, 16'hFFFF, 16'hFFFF, 64'hFFFE_0001, "w16_umax");

        // Start during CALC is ignored
        sm8 = 1'b0; m8 = 8'd3; q8 = 8'd5; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        step();
        start8 = 1'b1; m8 = 8'd9; q8 = 8'd9;
        step();
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 30) begin
            step();
            n++;
        end
        chk("t4_p", longint'(p8), 15);
        repeat (4) step();
        chk("t4_hold_p", longint'(p8), 15);
        chk("t4_idle_busy", longint'(busy8), 0);

        // Reset mid-operation aborts without a done pulse
        sm8 = 1'b0; m8 = 8'd100; q8 = 8'd100; start8 = 1'b1;
        step();
        start8 = 1'b0;
        repeat (3) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("t5_reset_p", longint'(p8), 0);
        chk("t5_reset_busy", longint'(busy8), 0);
        repeat (8) step();
        run_op(0, 1'b0, 16'd2, 16'd3, 64'd6, "t5_after");

        // Back-to-back random operations on both widths
        start8 = 1'b1; start16 = 1'b1;
        repeat (9000) begin
            sm8  = 1'($urandom_range(0, 1));
            sm16 = 1'($urandom_range(0, 1));
            m8   = 8'(pick(8));
            q8   = 8'(pick(8));
            m16  = pick(16);
            q16  = pick(16);
            step();
        end
        start8 = 1'b0; start16 = 1'b0;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
